shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Round-robin arbiter directly upstream of the shared 32-word data memory in the single-cycle manycore.
- Four core-side request ports compete for the one shared port; one access is serviced at a time.
- Drives the memory's read/write strobes, address, write data and access-enable.
- Returns read data to the winning core, plus a one-cycle done pulse that releases the core's stall.

Parameters:
- NUM_CORES, 4: number of requesting cores. The logic is written for 4; other values are unsupported.
- CNT_W, 16: width of the per-arbiter serviced-access counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  4  bit i: core i requests a shared access; held high until done[i].
- core_we  in  4  bit i: 1 = write, 0 = read; valid with core_req[i].
- core_addr  in  128  core i byte address in bits [32i+31:32i].
- core_wdata  in  128  core i write data in bits [32i+31:32i].
- done  out  4  one-hot, one-cycle completion pulse to the serviced core.
- core_rdata  out  32  registered read data; valid in the cycle done is high.
- mem_read  out  1  to shared memory read strobe.
- mem_write  out  1  to shared memory write strobe.
- mem_address  out  32  to shared memory address.
- mem_data_in  out  32  to shared memory write data.
- mem_data_out  in  32  from shared memory, combinational read data.
- shared_access  out  1  to shared memory access enable.
- busy  out  1  high whenever state is not IDLE.
- access_count  out  CNT_W  number of completed accesses; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - done, mem_read, mem_write, shared_access and busy go to 0.
  - core_rdata, mem_address, mem_data_in and access_count go to 0.
  - Round-robin pointer goes to 0, so core 0 has highest priority first.
- State machine: IDLE -> ACCESS -> DONE -> IDLE. Fixed 3-cycle service per access.
- IDLE:
  - If any core_req bit is set, pick a winner.
  - Search order is ptr, ptr+1, ... ptr+3, modulo 4.
  - Latch the winner index, its core_we, core_addr slice and core_wdata slice, then go to ACCESS.
  - If no request is present, stay in IDLE.
- ACCESS (exactly one cycle):
  - shared_access = 1; mem_address and mem_data_in come from the latched values.
  - mem_read = ~latched_we; mem_write = latched_we.
  - On the closing edge:
    - core_rdata <= mem_data_out for reads; core_rdata is held unchanged for writes.
    - ptr <= winner+1 (mod 4).
    - access_count increments.
    - State goes to DONE.
- DONE (one cycle):
  - done[winner] = 1; all memory strobes and shared_access are 0.
  - Go to IDLE.
  - A request still high in DONE is ignored; arbitration happens only in IDLE.
- Latency: request seen in IDLE at cycle N; memory access in cycle N+1; done and rdata in cycle N+2. Peak throughput is 1 access per 3 cycles.
- Memory strobes are never asserted outside ACCESS. mem_read and mem_write are never both 1.
- Request inputs are sampled only at the IDLE->ACCESS edge.
  - Changes to core_addr, core_wdata or core_we after that edge do not affect the access in flight.
  - core_req deasserted during ACCESS or DONE: the access still completes and done still pulses.
- Simultaneous requests: exactly one grant per service. Any continuously requesting core is served within 4 services (at most 12 cycles after entering IDLE).
- Address alignment and range checks are the memory's job; addresses pass through unmodified.
- Reset during ACCESS: mem_write drops asynchronously before the next edge, so no write occurs. No done pulse is issued. The interrupted request is re-arbitrated from ptr=0 once it is re-presented.
- access_count wraps from 0xFFFF to 0 with no flag.

Test Plan:
- Single read, memory preloaded with word i = 100+i:
  - Stimulus: after reset, core 2 requests a read of address 12.
  - Response: mem_read=1 and shared_access=1 in cycle 1; done=4'b0100 and core_rdata=103 in cycle 2; access_count=1.
- Write then read back:
  - Stimulus: core 1 writes 156 to address 28; after done, core 1 reads address 28.
  - Response: mem_write is high for exactly one cycle; the second done returns core_rdata=156.
- Four simultaneous requests after reset:
  - Stimulus: all four cores request reads of addresses 0, 4, 8, 12; each core drops its request on its own done.
  - Response: done pulses in order core0, core1, core2, core3 every 3 cycles, with rdata 100, 101, 102, 103.
- Fairness:
  - Stimulus: core 0 requests continuously while core 3 requests once.
  - Response: after core 0's first service, core 3 is served next, before core 0 again.
- Input change mid-access:
  - Stimulus: core 0 requests a read of address 16; core_addr changes to 20 during ACCESS.
  - Response: core_rdata=104, with mem_address held at 16 for the whole ACCESS cycle.
- Reset mid-operation:
  - Stimulus: assert reset during the ACCESS cycle of a write of 999 to address 0.
  - Response: all outputs are 0 immediately; word 0 still reads 100 afterwards; no done pulse; busy=0.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
//   Round-robin arbiter in front of the shared 32-word data memory. Four cores
//   compete for the single memory port. Each access takes three cycles:
//   IDLE (arbitrate) -> ACCESS (drive memory) -> DONE (pulse done).
//   All outputs are registered. They come straight from flops that are cleared
//   by the asynchronous reset, so a reset in the middle of an access removes the
//   memory strobes at once.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   core_req       in   per-core request, held until done[i]
//   core_we        in   per-core write enable (1 = write)
//   core_addr      in   per-core 32-bit address, core i in [32i+31:32i]
//   core_wdata     in   per-core 32-bit write data, core i in [32i+31:32i]
//   done           out  one-hot single-cycle completion pulse
//   core_rdata     out  read data, valid while done is high
//   mem_read       out  memory read strobe (ACCESS cycle only)
//   mem_write      out  memory write strobe (ACCESS cycle only)
//   mem_address    out  memory address
//   mem_data_in    out  memory write data
//   mem_data_out   in   memory combinational read data
//   shared_access  out  memory access enable (ACCESS cycle only)
//   busy           out  high whenever the FSM is not in IDLE
//   access_count   out  count of completed accesses, wraps
// -----------------------------------------------------------------------------
module shared_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    core_req,
  input  logic [NUM_CORES-1:0]    core_we,
  input  logic [32*NUM_CORES-1:0] core_addr,
  input  logic [32*NUM_CORES-1:0] core_wdata,
  output logic [NUM_CORES-1:0]    done,
  output logic [31:0]             core_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [31:0]             mem_address,
  output logic [31:0]             mem_data_in,
  input  logic [31:0]             mem_data_out,
  output logic                    shared_access,
  output logic                    busy,
  output logic [CNT_W-1:0]        access_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t                 state_q;
  logic [1:0]             ptr_q;
  logic [1:0]             win_q;
  logic                   we_q;
  logic [NUM_CORES-1:0]   done_q;
  logic [31:0]            rdata_q;
  logic                   rd_q;
  logic                   wr_q;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic                   acc_q;
  logic                   busy_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [1:0]             win_s;
  logic                   found_s;
  logic [1:0]             idx_s;

  // Round-robin search: the first requester at or after ptr_q (mod 4) wins.
  always_comb begin
    win_s   = 2'd0;
    found_s = 1'b0;
    idx_s   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx_s = ptr_q + 2'(k);
      if (!found_s && core_req[idx_s]) begin
        win_s   = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Service FSM, which also holds every registered output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      we_q    <= 1'b0;
      done_q  <= '0;
      rdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= '0;
          if (found_s) begin
            // Latch the winner's request so that later input changes cannot
            // disturb the access in flight.
            win_q   <= win_s;
            we_q    <= core_we[win_s];
            addr_q  <= core_addr[32*win_s +: 32];
            wdata_q <= core_wdata[32*win_s +: 32];
            rd_q    <= ~core_we[win_s];
            wr_q    <= core_we[win_s];
            acc_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_ACCESS;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          rd_q   <= 1'b0;
          wr_q   <= 1'b0;
          acc_q  <= 1'b0;
          if (!we_q) begin
            rdata_q <= mem_data_out;
          end else begin
            rdata_q <= rdata_q;
          end
          ptr_q   <= win_q + 2'd1;
          cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          done_q  <= {{(NUM_CORES-1){1'b0}}, 1'b1} << win_q;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          // Requests still high here are ignored; arbitration is only in IDLE.
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= '0;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          acc_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign done          = done_q;
  assign core_rdata    = rdata_q;
  assign mem_read      = rd_q;
  assign mem_write     = wr_q;
  assign mem_address   = addr_q;
  assign mem_data_in   = wdata_q;
  assign shared_access = acc_q;
  assign busy          = busy_q;
  assign access_count  = cnt_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_arbiter
//   Directed bench for shared_mem_arbiter. It models a 32-word memory that is
//   preloaded with word i = 100 + i. The stimulus pushes the done pulses,
//   read data and access counts it expects into a queue. A monitor process
//   pops that queue on every done pulse and compares.
// -----------------------------------------------------------------------------
module tb_shared_mem_arbiter;

  logic          clk;
  logic          reset;
  logic [3:0]    core_req;
  logic [3:0]    core_we;
  logic [127:0]  core_addr;
  logic [127:0]  core_wdata;
  logic [3:0]    done;
  logic [31:0]   core_rdata;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   mem_address;
  logic [31:0]   mem_data_in;
  logic [31:0]   mem_data_out;
  logic          shared_access;
  logic          busy;
  logic [15:0]   access_count;

  shared_mem_arbiter #(.NUM_CORES(4), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .done          (done),
    .core_rdata    (core_rdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .shared_access (shared_access),
    .busy          (busy),
    .access_count  (access_count)
  );

  // Shared memory model
  logic [31:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'(100 + i);
  end
  always @(posedge clk) begin
    if (shared_access && mem_write) mem[mem_address[6:2]] <= mem_data_in;
  end
  assign mem_data_out = mem[mem_address[6:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  done;
    logic        chk_rdata;
    logic [31:0] rdata;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_count = 16'd0;
  logic [3:0]  hold = 4'd0;
  int          wr_hi = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic issue(input int c, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    core_we[c]             = we;
    core_addr[32*c +: 32]  = addr;
    core_wdata[32*c +: 32] = wd;
    core_req[c]            = 1'b1;
  endtask

  task automatic expect_done(input int c, input logic chk_rd, input logic [31:0] rd);
    exp_t e;
    exp_count   = exp_count + 16'd1;
    e.done      = 4'd1 << c;
    e.chk_rdata = chk_rd;
    e.rdata     = rd;
    e.cnt       = exp_count;
    exp_q.push_back(e);
  endtask

  // Act as the cores: drop a request on its done pulse (bits in hold stay
  // high until hold_n pulses have been seen). Return once idle, or flag a timeout.
  task automatic wait_idle(input int max_cycles, input int hold_n);
    int n;
    int cyc;
    n   = 0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (mem_write) wr_hi++;
      if (done != 4'd0) begin
        n++;
        if (n >= hold_n) hold = 4'd0;
        core_req = core_req & ~(done & ~hold);
      end
      if (core_req == 4'd0 && !busy) break;
      if (cyc >= max_cycles) begin
        tests++;
        fails++;
        $display("FAIL wait_idle timeout: req=%b busy=%b after %0d cycles", core_req, busy, cyc);
        core_req = 4'd0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    core_req = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_count = 16'd0;
  endtask

  // Monitor: compare each done pulse against the queue; check strobe rules every cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("protocol", {31'd0, (!(mem_read && mem_write)) && $onehot0(done) &&
            (shared_access || !(mem_read || mem_write)) &&
            (done == 4'd0 || !(shared_access || mem_read || mem_write))}, 32'd1);
        if (done != 4'd0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", {28'd0, done}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("done_vec", {28'd0, done}, {28'd0, e.done});
            if (e.chk_rdata) chk("core_rdata", core_rdata, e.rdata);
            chk("access_count", {16'd0, access_count}, {16'd0, e.cnt});
          end
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    core_req   = 4'd0;
    core_we    = 4'd0;
    core_addr  = 128'd0;
    core_wdata = 128'd0;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_done", {28'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_strobes", {29'd0, mem_read, mem_write, shared_access}, 32'd0);
    chk("rst_rdata", core_rdata, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_count", {16'd0, access_count}, 32'd0);

    // Single read: core 2 reads address 12
    issue(2, 1'b0, 32'd12, 32'd0);
    expect_done(2, 1'b1, 32'd103);
    @(posedge clk); #1;
    chk("t1_mem_read", {31'd0, mem_read}, 32'd1);
    chk("t1_shared_access", {31'd0, shared_access}, 32'd1);
    chk("t1_mem_write", {31'd0, mem_write}, 32'd0);
    chk("t1_mem_address", mem_address, 32'd12);
    wait_idle(20, 1);

    // Write 156 to address 28, then read it back; rdata holds 103 across the write
    issue(1, 1'b1, 32'd28, 32'd156);
    expect_done(1, 1'b1, 32'd103);
    wr_hi = 0;
    wait_idle(20, 1);
    chk("t2_write_cycles", 32'(wr_hi), 32'd1);
    issue(1, 1'b0, 32'd28, 32'd0);
    expect_done(1, 1'b1, 32'd156);
    wait_idle(20, 1);

    // Four simultaneous requests after reset: served 0,1,2,3
    do_reset();
    for (int c = 0; c < 4; c++) begin
      issue(c, 1'b0, 32'(4 * c), 32'd0);
      expect_done(c, 1'b1, 32'(100 + c));
    end
    wait_idle(40, 1);

    // Fairness: core 0 holds its request, core 3 asks once
    hold = 4'b0001;
    issue(0, 1'b0, 32'd0, 32'd0);
    issue(3, 1'b0, 32'd8, 32'd0);
    expect_done(0, 1'b1, 32'd100);
    expect_done(3, 1'b1, 32'd102);
    expect_done(0, 1'b1, 32'd100);
    wait_idle(40, 3);

    // Address changes during ACCESS must not affect the access
    issue(0, 1'b0, 32'd16, 32'd0);
    expect_done(0, 1'b1, 32'd104);
    @(posedge clk); #1;
    core_addr[31:0] = 32'd20;
    @(negedge clk);
    chk("t5_mem_address", mem_address, 32'd16);
    chk("t5_mem_read", {31'd0, mem_read}, 32'd1);
    wait_idle(20, 1);

    // Reset during the ACCESS cycle of a write of 999 to address 0
    issue(0, 1'b1, 32'd0, 32'd999);
    @(posedge clk); #1;
    chk("t6_write_started", {31'd0, mem_write}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_strobes", {29'd0, mem_read, mem_write, shared_access}, 32'd0);
    chk("t6_done", {28'd0, done}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_rdata", core_rdata, 32'd0);
    chk("t6_count", {16'd0, access_count}, 32'd0);
    chk("t6_addr_data", mem_address | mem_data_in, 32'd0);
    core_req = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_count = 16'd0;
    repeat (3) @(negedge clk);
    chk("t6_busy_after", {31'd0, busy}, 32'd0);
    issue(0, 1'b0, 32'd0, 32'd0);
    expect_done(0, 1'b1, 32'd100);
    wait_idle(20, 1);

    repeat (2) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
